// File: rtl/sh_frt_pkg.sv
// Shared definitions for the SH free-running timer: register offsets, CTRL/STAT
// layouts, clock-select encodings and byte-enable helpers.
`timescale 1ns/1ps
package sh_frt_pkg;

    localparam logic [5:0] OFF_CTRL = 6'h00;
    localparam logic [5:0] OFF_STAT = 6'h04;
    localparam logic [5:0] OFF_IER  = 6'h08;
    localparam logic [5:0] OFF_CNT  = 6'h0C;
    localparam logic [5:0] OFF_OCR0 = 6'h10;
    localparam logic [5:0] OFF_OLVL = 6'h20;
    localparam logic [5:0] OFF_ICR0 = 6'h30;

    localparam logic [1:0] CKS_DIV8   = 2'd0;
    localparam logic [1:0] CKS_DIV32  = 2'd1;
    localparam logic [1:0] CKS_DIV128 = 2'd2;
    localparam logic [1:0] CKS_FTCI   = 2'd3;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  iedg;
        logic [3:0]  rsvd_lo;
        logic        run;
        logic        cclr;
        logic [1:0]  cks;
    } CTRL_t;

    // Also used for IER, which shares the STAT bit positions.
    typedef struct packed {
        logic [7:0]  icovr;
        logic [6:0]  rsvd;
        logic        ovf;
        logic [7:0]  icf;
        logic [7:0]  ocf;
    } STAT_t;

    localparam CTRL_t CTRL_RST = '0;
    localparam STAT_t STAT_RST = '0;

    function automatic logic [31:0] be_mask(input logic [3:0] ba);
        return {{8{ba[3]}}, {8{ba[2]}}, {8{ba[1]}}, {8{ba[0]}}};
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] di,
                                             input logic [3:0]  ba);
        logic [31:0] m;
        m = be_mask(ba);
        return (old_word & ~m) | (di & m);
    endfunction

endpackage

// File: rtl/sh_frt_gen_if.sv
// IBUS register-bus bundle between the core (master) and the timer (slave).
`timescale 1ns/1ps
interface sh_frt_gen_if;
    logic [31:0] ibus_a;
    logic [31:0] ibus_di;
    logic [3:0]  ibus_ba;
    logic        ibus_we;
    logic        ibus_req;
    logic [31:0] ibus_do;
    logic        ibus_busy;
    logic        ibus_act;

    modport master (output ibus_a, ibus_di, ibus_ba, ibus_we, ibus_req,
                    input  ibus_do, ibus_busy, ibus_act);
    modport slave  (input  ibus_a, ibus_di, ibus_ba, ibus_we, ibus_req,
                    output ibus_do, ibus_busy, ibus_act);
endinterface

// File: rtl/sh_frt_capture.sv
// One input-capture channel: 2-flop sync, optional 3-sample glitch filter
// (FRT_IC_FILTER_EN), selected-edge detect, ICR/ICF/ICOVR.
`timescale 1ns/1ps
module sh_frt_capture
    import sh_frt_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             fti,
    input  logic             iedg,
    input  logic [CNT_W-1:0] cnt,
    input  logic             icf_clr,
    input  logic             icovr_clr,
    output logic [CNT_W-1:0] icr,
    output logic             icf,
    output logic             icovr
);

    logic             sync1_reg, sync2_reg, level_reg;
    logic [CNT_W-1:0] icr_reg;
    logic             icf_reg, icovr_reg;
    logic             stable, edge_det;

`ifdef FRT_IC_FILTER_EN
    logic hist1_reg, hist2_reg;
    // The level is accepted only once three consecutive samples agree.
    assign stable = (sync2_reg == hist1_reg) && (sync2_reg == hist2_reg);
`else
    assign stable = 1'b1;
`endif

    assign edge_det = stable && (sync2_reg != level_reg) && (sync2_reg == iedg);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            icr_reg   <= '0;
            icf_reg   <= 1'b0;
            icovr_reg <= 1'b0;
`ifdef FRT_IC_FILTER_EN
            hist1_reg <= 1'b0;
            hist2_reg <= 1'b0;
`endif
        end else if (CE) begin
            sync1_reg <= fti;
            sync2_reg <= sync1_reg;
`ifdef FRT_IC_FILTER_EN
            hist1_reg <= sync2_reg;
            hist2_reg <= hist1_reg;
`endif
            if (stable)
                level_reg <= sync2_reg;
            if (edge_det)
                icr_reg <= cnt;
            icf_reg   <= edge_det | (icf_reg & ~icf_clr);
            icovr_reg <= (edge_det & icf_reg) | (icovr_reg & ~icovr_clr);
        end
    end

    assign icr   = icr_reg;
    assign icf   = icf_reg;
    assign icovr = icovr_reg;

endmodule

// File: rtl/sh_frt_gen.sv
// Free-running timer with output compare and input capture on IBUS.
// Build option FRT_IC_FILTER_EN adds a glitch filter to every capture input.
`timescale 1ns/1ps
module sh_frt_gen
    import sh_frt_pkg::*;
#(
    parameter int          CNT_W = 16,
    parameter int          OC_N  = 2,
    parameter int          IC_N  = 1,
    parameter logic [31:0] BASE  = 32'hFFFFFE10
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic            CLK8_CE,
    input  logic            CLK32_CE,
    input  logic            CLK128_CE,
    input  logic            FTCI,
    input  logic [IC_N-1:0] FTI,
    output logic [OC_N-1:0] FTO,
    sh_frt_gen_if.slave     ibus,
    output logic [OC_N-1:0] OC_IRQ,
    output logic [IC_N-1:0] IC_IRQ,
    output logic            OV_IRQ
);

    localparam logic [7:0] IC_MASK = 8'((1 << IC_N) - 1);

    logic [31:0] rel_addr, w1c, rd_word;
    logic [5:0]  off;
    logic        hit, wr, rd;

    CTRL_t            ctrl_reg, ctrl_clean;
    logic [OC_N-1:0]  ocie_reg, olvl_reg;
    logic [IC_N-1:0]  icie_reg;
    logic             ovie_reg, ovf_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       ftci_sync_reg;
    logic [31:0]      rdata_reg;

    logic [CNT_W-1:0] ocr_arr [OC_N];
    logic [OC_N-1:0]  ocf_vec, fto_vec;
    logic [CNT_W-1:0] icr_arr [IC_N];
    logic [IC_N-1:0]  icf_vec, icovr_vec;

    STAT_t       stat_word, ier_word;
    logic [31:0] ctrl_new, ier_new, olvl_new, cnt_new;
    logic        ftci_rise, sel_ce, tick, clr_match;
    logic        unused_bits;

    // Window may start on any word boundary, so decode relative to BASE.
    assign rel_addr       = ibus.ibus_a - BASE;
    assign ibus.ibus_act  = (rel_addr[31:6] == 26'd0);
    assign ibus.ibus_busy = 1'b0;
    assign ibus.ibus_do   = rdata_reg;
    assign off            = {rel_addr[5:2], 2'b00};
    assign hit            = ibus.ibus_req & ibus.ibus_act;
    assign wr             = hit & ibus.ibus_we;
    assign rd             = hit & ~ibus.ibus_we;
    assign w1c = (wr && off == OFF_STAT) ? (ibus.ibus_di & be_mask(ibus.ibus_ba)) : 32'd0;

    assign ftci_rise = ftci_sync_reg[1] & ~ftci_sync_reg[2];

    always_comb begin
        sel_ce = CLK8_CE;
        case (ctrl_reg.cks)
            CKS_DIV8:   sel_ce = CLK8_CE;
            CKS_DIV32:  sel_ce = CLK32_CE;
            CKS_DIV128: sel_ce = CLK128_CE;
            CKS_FTCI:   sel_ce = ftci_rise;
            default:    sel_ce = CLK8_CE;
        endcase
    end

    assign tick      = CE & ctrl_reg.run & sel_ce;
    assign clr_match = ctrl_reg.cclr && (cnt_reg == ocr_arr[0]);

    always_comb begin
        stat_word       = STAT_RST;
        stat_word.ocf   = 8'(ocf_vec);
        stat_word.icf   = 8'(icf_vec);
        stat_word.ovf   = ovf_reg;
        stat_word.icovr = 8'(icovr_vec);
        ier_word        = STAT_RST;
        ier_word.ocf    = 8'(ocie_reg);
        ier_word.icf    = 8'(icie_reg);
        ier_word.ovf    = ovie_reg;
    end

    assign ctrl_new = be_merge(ctrl_reg, ibus.ibus_di, ibus.ibus_ba);
    assign ier_new  = be_merge(ier_word, ibus.ibus_di, ibus.ibus_ba);
    assign olvl_new = be_merge(32'(olvl_reg), ibus.ibus_di, ibus.ibus_ba);
    assign cnt_new  = be_merge(32'(cnt_reg), ibus.ibus_di, ibus.ibus_ba);

    always_comb begin
        ctrl_clean         = CTRL_t'(ctrl_new);
        ctrl_clean.rsvd_hi = '0;
        ctrl_clean.rsvd_lo = '0;
        ctrl_clean.iedg    = ctrl_clean.iedg & IC_MASK;
    end

    always_comb begin
        rd_word = 32'd0;
        case (off)
            OFF_CTRL: rd_word = ctrl_reg;
            OFF_STAT: rd_word = stat_word;
            OFF_IER:  rd_word = ier_word;
            OFF_CNT:  rd_word = 32'(cnt_reg);
            OFF_OLVL: rd_word = 32'(olvl_reg);
            default:  rd_word = 32'd0;
        endcase
        for (int k = 0; k < OC_N; k++)
            if (off == OFF_OCR0 + 6'(4 * k)) rd_word = 32'(ocr_arr[k]);
        for (int k = 0; k < IC_N; k++)
            if (off == OFF_ICR0 + 6'(4 * k)) rd_word = 32'(icr_arr[k]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_reg      <= CTRL_RST;
            ocie_reg      <= '0;
            icie_reg      <= '0;
            ovie_reg      <= 1'b0;
            olvl_reg      <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            ftci_sync_reg <= '0;
            rdata_reg     <= 32'd0;
        end else if (CE) begin
            ftci_sync_reg <= {ftci_sync_reg[1:0], FTCI};
            if (wr && off == OFF_CTRL)
                ctrl_reg <= ctrl_clean;
            if (wr && off == OFF_IER) begin
                ocie_reg <= ier_new[OC_N-1:0];
                icie_reg <= ier_new[8 +: IC_N];
                ovie_reg <= ier_new[16];
            end
            if (wr && off == OFF_OLVL)
                olvl_reg <= olvl_new[OC_N-1:0];
            // A software write to CNT takes priority over the tick.
            if (wr && off == OFF_CNT)
                cnt_reg <= cnt_new[CNT_W-1:0];
            else if (tick)
                cnt_reg <= clr_match ? '0 : cnt_reg + CNT_W'(1);
            ovf_reg <= (tick & (&cnt_reg)) | (ovf_reg & ~w1c[16]);
            if (rd)
                rdata_reg <= rd_word;
        end
    end

    for (genvar gi = 0; gi < OC_N; gi++) begin : g_oc
        logic [CNT_W-1:0] ocr_reg;
        logic             ocf_reg, fto_reg, ocr_wr, match;
        logic [31:0]      ocr_new;
        logic             unused_ocr;

        assign ocr_wr     = wr && (off == OFF_OCR0 + 6'(4 * gi));
        assign ocr_new    = be_merge(32'(ocr_reg), ibus.ibus_di, ibus.ibus_ba);
        assign unused_ocr = ^ocr_new;
        // Compare uses the registered OCR, so a same-cycle write cannot match.
        assign match      = tick && (cnt_reg == ocr_reg);

        always_ff @(posedge CLK) begin
            if (RST) begin
                ocr_reg <= '0;
                ocf_reg <= 1'b0;
                fto_reg <= 1'b0;
            end else if (CE) begin
                if (ocr_wr)
                    ocr_reg <= ocr_new[CNT_W-1:0];
                ocf_reg <= match | (ocf_reg & ~w1c[gi]);
                if (match)
                    fto_reg <= olvl_reg[gi];
            end
        end

        assign ocr_arr[gi] = ocr_reg;
        assign ocf_vec[gi] = ocf_reg;
        assign fto_vec[gi] = fto_reg;
    end

    for (genvar gi = 0; gi < IC_N; gi++) begin : g_ic
        sh_frt_capture #(.CNT_W(CNT_W)) u_cap (
            .CLK       (CLK),
            .RST       (RST),
            .CE        (CE),
            .fti       (FTI[gi]),
            .iedg      (ctrl_reg.iedg[gi]),
            .cnt       (cnt_reg),
            .icf_clr   (w1c[8 + gi]),
            .icovr_clr (w1c[24 + gi]),
            .icr       (icr_arr[gi]),
            .icf       (icf_vec[gi]),
            .icovr     (icovr_vec[gi])
        );
    end

    assign FTO    = fto_vec;
    assign OC_IRQ = ocf_vec & ocie_reg;
    assign IC_IRQ = icf_vec & icie_reg;
    assign OV_IRQ = ovf_reg & ovie_reg;

    assign unused_bits = ^{rel_addr[1:0], ier_new, olvl_new, cnt_new, w1c};

endmodule
